alu_exec_unit: RTL and testbench
================================

Name: alu_exec_unit

Overview:
- Execute-stage ALU, directly downstream of the ALU control decoder; consumes its 4-bit ALU control code plus two register operands.
- Single-cycle ops (AND, ORR, ADD, SUB, pass-B, NOR) return a registered result one cycle after accept.
- MUL (LEGv8, low half of the product) runs as an iterative shift-add over WIDTH cycles.
- Valid/ready handshakes on both sides let the surrounding datapath stall while the unit is busy.

Parameters:
- WIDTH, 64, operand/result width in bits (>= 2; counter width is $clog2(WIDTH)).

Ports:
- CLK  in  1  rising-edge clock
- RST_N  in  1  asynchronous active-low reset
- IN_VALID  in  1  operation request
- IN_READY  out  1  unit can accept; high only in IDLE
- ALU_CTRL  in  4  control code: 0000 AND, 0001 ORR, 0010 ADD, 0110 SUB, 0111 pass B, 1100 NOR, 1000 MUL
- A  in  WIDTH  operand A (Rn)
- B  in  WIDTH  operand B (Rm / immediate)
- OUT_VALID  out  1  RESULT/ZERO/ILLEGAL valid
- OUT_READY  in  1  consumer takes the result
- RESULT  out  WIDTH  result, modulo 2^WIDTH
- ZERO  out  1  RESULT == 0
- ILLEGAL  out  1  ALU_CTRL was not a listed code

Behaviour:
- Reset: while RST_N is low, immediately (asynchronously) force state=IDLE, RESULT=0, ZERO=0, ILLEGAL=0, OUT_VALID=0 and clear the counter and multiplier registers. IN_READY=1 once reset is released.
- Reset mid-operation: the operation is aborted and never reported. The first accept after reset is a fresh operation.
- Accept: a transfer occurs when IN_VALID && IN_READY on a rising edge. A, B and ALU_CTRL are sampled only at accept; later changes have no effect.
- State IDLE, on accept with a single-cycle code:
  - Compute and register RESULT, ZERO and ILLEGAL=0, then go to HOLD.
  - OUT_VALID rises on the edge after accept (latency 1).
- State IDLE, on accept with 1000 (MUL):
  - Load mcand=A, mplier=B, acc=0, cnt=0; go to MUL.
- State MUL, each cycle:
  - If mplier[0], acc += mcand (mod 2^WIDTH); then mcand <<= 1, mplier >>= 1, cnt++.
  - When cnt == WIDTH-1 completes, register RESULT=acc and ZERO, then go to HOLD.
  - Fixed latency: OUT_VALID is high exactly WIDTH+1 edges after the accept edge. No early termination.
- Illegal code: RESULT=0, ZERO=1, ILLEGAL=1, latency 1 via HOLD.
- State HOLD:
  - OUT_VALID=1; RESULT, ZERO and ILLEGAL held stable.
  - When OUT_READY=1 on an edge, go to IDLE with OUT_VALID=0 on that edge.
- Stalls: IN_READY=0 in MUL and HOLD, and IN_VALID is ignored there. There is no accept in the same cycle as result retirement, so at most one operation is in flight.
- Arithmetic: SUB = A + ~B + 1. Pass-B gives RESULT=B, so ZERO drives CBZ. Carry-out and overflow are discarded.
- OUT_VALID and IN_READY are never high together.

Decomposition:
- Shared package alu_pkg holds:
  - ALU control code localparams (ALU_AND, ALU_ORR, ALU_ADD, ALU_SUB, ALU_PASSB, ALU_NOR, ALU_MUL), shared with the ALU control decoder.
  - The state encoding: IDLE=2'b00, MUL=2'b01, HOLD=2'b10.
- One natural sub-module, shift_add_mul:
  - Owns mcand, mplier, acc and cnt.
  - Ports: CLK, RST_N, start, A, B, done, product.
  - The top FSM instantiates it and waits on done.

Test Plan:
- ADD: A=5, B=7, ALU_CTRL=0010 -> OUT_VALID one edge after accept, RESULT=12, ZERO=0, ILLEGAL=0. SUB 0-1 -> RESULT=0xFFFF_FFFF_FFFF_FFFF.
- Zero flag: SUB A=B=0x1234 -> RESULT=0, ZERO=1. Pass-B with B=0 -> ZERO=1. NOR A=0, B=0 -> all ones.
- MUL: A=3, B=0xFFFF_FFFF_FFFF_FFFF -> IN_READY low for 65 edges, OUT_VALID exactly 65 edges after accept, RESULT=0xFFFF_FFFF_FFFF_FFFD. Also A=0x1_0000_0000, B=0x1_0000_0000 -> RESULT=0, ZERO=1.
- Backpressure: after an ADD, hold OUT_READY=0 for 5 cycles while presenting a new IN_VALID -> RESULT stable, new op not accepted. Assert OUT_READY -> IDLE next edge, the new op is accepted on the following edge.
- Reset: assert RST_N=0 mid-MUL (cycle 20) between clock edges -> OUT_VALID, RESULT and ZERO go to 0 without waiting for an edge. After release, IN_READY=1 and an ADD 1+1 returns RESULT=2.
- Illegal code ALU_CTRL=1111 -> OUT_VALID after 1 edge, RESULT=0, ZERO=1, ILLEGAL=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes (common with the ALU control decoder)
// and the execute-unit state encoding.
package alu_pkg;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_ORR   = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_PASSB = 4'b0111;
  localparam logic [3:0] ALU_NOR   = 4'b1100;
  localparam logic [3:0] ALU_MUL   = 4'b1000;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_MUL  = 2'b01;
  localparam logic [1:0] ST_HOLD = 2'b10;

  function automatic logic is_legal(input logic [3:0] ctrl);
    case (ctrl)
      ALU_AND, ALU_ORR, ALU_ADD, ALU_SUB,
      ALU_PASSB, ALU_NOR, ALU_MUL: is_legal = 1'b1;
      default:                     is_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/shift_add_mul.sv
// Iterative shift-add multiplier returning the low WIDTH bits of A*B.
// done pulses for one cycle once all WIDTH iterations have been applied.
module shift_add_mul #(
  parameter int WIDTH = 64
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             busy;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        mcand  <= A;
        mplier <= B;
        acc    <= '0;
        cnt    <= '0;
        busy   <= 1'b1;
      end else if (busy) begin
        // Always run every bit: latency stays fixed regardless of operands.
        if (mplier[0]) acc <= acc + mcand;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + CNT_W'(1);
        if (cnt == CNT_LAST) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign product = acc;

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle logic/arith ops, iterative MUL, with
// valid/ready on both sides and a HOLD state that parks the result.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [3:0]       ALU_CTRL,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] RESULT,
  output logic             ZERO,
  output logic             ILLEGAL
);

  logic [1:0]       state_p0;
  logic [WIDTH-1:0] result_p1;
  logic             zero_p1;
  logic             illegal_p1;
  logic             accept_p0;
  logic             mul_start;
  logic             mul_done;
  logic [WIDTH-1:0] mul_product;
  logic [WIDTH-1:0] op_res_p0;

  // Unlisted codes fall to zero, which also yields ZERO=1 for them.
  function automatic logic [WIDTH-1:0] alu_op(input logic [3:0] ctrl,
                                               input logic signed [WIDTH-1:0] a,
                                               input logic signed [WIDTH-1:0] b);
    logic signed [WIDTH-1:0] r;
    case (ctrl)
      ALU_AND:   r = a & b;
      ALU_ORR:   r = a | b;
      ALU_ADD:   r = a + b;
      ALU_SUB:   r = a + ~b + WIDTH'(1);
      ALU_PASSB: r = b;
      ALU_NOR:   r = ~(a | b);
      default:   r = '0;
    endcase
    return $unsigned(r);
  endfunction

  assign accept_p0 = IN_VALID && (state_p0 == ST_IDLE);
  assign mul_start = accept_p0 && (ALU_CTRL == ALU_MUL);
  assign op_res_p0 = alu_op(ALU_CTRL, $signed(A), $signed(B));

  shift_add_mul #(.WIDTH(WIDTH)) u_mul (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .start   (mul_start),
    .A       (A),
    .B       (B),
    .done    (mul_done),
    .product (mul_product)
  );

  // Stage boundary: accept (or multiplier completion) -> registered result
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_p0   <= ST_IDLE;
      result_p1  <= '0;
      zero_p1    <= 1'b0;
      illegal_p1 <= 1'b0;
    end else begin
      case (state_p0)
        ST_IDLE: begin
          if (accept_p0) begin
            if (ALU_CTRL == ALU_MUL) begin
              state_p0 <= ST_MUL;
            end else begin
              result_p1  <= op_res_p0;
              zero_p1    <= (op_res_p0 == '0);
              illegal_p1 <= !is_legal(ALU_CTRL);
              state_p0   <= ST_HOLD;
            end
          end
        end
        ST_MUL: begin
          if (mul_done) begin
            result_p1  <= mul_product;
            zero_p1    <= (mul_product == '0);
            illegal_p1 <= 1'b0;
            state_p0   <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (OUT_READY) state_p0 <= ST_IDLE;
        end
        default: state_p0 <= ST_IDLE;
      endcase
    end
  end

  assign IN_READY  = (state_p0 == ST_IDLE);
  assign OUT_VALID = (state_p0 == ST_HOLD);
  assign RESULT    = result_p1;
  assign ZERO      = zero_p1;
  assign ILLEGAL   = illegal_p1;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit (WIDTH=64) with hand-computed expectations.
module tb_alu_exec_unit;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        IN_VALID;
  logic        IN_READY;
  logic [3:0]  ALU_CTRL;
  logic [63:0] A;
  logic [63:0] B;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [63:0] RESULT;
  logic        ZERO;
  logic        ILLEGAL;

  int checks = 0;
  int failures = 0;

  logic [3:0]  v_ctl [8];
  logic [63:0] v_a   [8];
  logic [63:0] v_b   [8];
  logic [63:0] v_r   [8];
  logic        v_z   [8];

  alu_exec_unit #(.WIDTH(64)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .ALU_CTRL  (ALU_CTRL),
    .A         (A),
    .B         (B),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .RESULT    (RESULT),
    .ZERO      (ZERO),
    .ILLEGAL   (ILLEGAL)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Present one request for a single edge, then scramble the operand inputs.
  task automatic issue(input logic [3:0] c, input logic [63:0] a, input logic [63:0] b);
    @(negedge CLK);
    ALU_CTRL = c; A = a; B = b; IN_VALID = 1'b1;
    @(posedge CLK);
    #1;
    IN_VALID = 1'b0;
    A = 64'hDEAD_BEEF_CAFE_F00D;
    B = 64'h0BAD_F00D_1234_5678;
    ALU_CTRL = 4'b0010;
  endtask

  task automatic retire();
    @(negedge CLK);
    OUT_READY = 1'b1;
    @(posedge CLK);
    #1;
    OUT_READY = 1'b0;
  endtask

  task automatic test_reset();
    RST_N = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b0;
    ALU_CTRL = 4'b0; A = '0; B = '0;
    #2;
    checks++;
    if (OUT_VALID !== 1'b0 || RESULT !== 64'd0 || ZERO !== 1'b0 || ILLEGAL !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: got vld=%b res=%h z=%b ill=%b, want 0/0/0/0",
               OUT_VALID, RESULT, ZERO, ILLEGAL);
    end
    @(posedge CLK); @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    #1;
    checks++;
    if (IN_READY !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready: got %b, want 1", IN_READY);
    end
  endtask

  task automatic test_single_cycle();
    v_ctl[0] = 4'b0010; v_a[0] = 64'd5;      v_b[0] = 64'd7;      v_r[0] = 64'd12;     v_z[0] = 1'b0;
    v_ctl[1] = 4'b0110; v_a[1] = 64'd0;      v_b[1] = 64'd1;      v_r[1] = '1;         v_z[1] = 1'b0;
    v_ctl[2] = 4'b0110; v_a[2] = 64'h1234;   v_b[2] = 64'h1234;   v_r[2] = 64'd0;      v_z[2] = 1'b1;
    v_ctl[3] = 4'b0111; v_a[3] = 64'h55;     v_b[3] = 64'd0;      v_r[3] = 64'd0;      v_z[3] = 1'b1;
    v_ctl[4] = 4'b1100; v_a[4] = 64'd0;      v_b[4] = 64'd0;      v_r[4] = '1;         v_z[4] = 1'b0;
    v_ctl[5] = 4'b0000; v_a[5] = 64'hF0;     v_b[5] = 64'h3C;     v_r[5] = 64'h30;     v_z[5] = 1'b0;
    v_ctl[6] = 4'b0001; v_a[6] = 64'hF0;     v_b[6] = 64'h0F;     v_r[6] = 64'hFF;     v_z[6] = 1'b0;
    v_ctl[7] = 4'b0111; v_a[7] = 64'h99;     v_b[7] = 64'hABC;    v_r[7] = 64'hABC;    v_z[7] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      issue(v_ctl[i], v_a[i], v_b[i]);
      checks++;
      if (OUT_VALID !== 1'b1 || IN_READY !== 1'b0 || RESULT !== v_r[i] ||
          ZERO !== v_z[i] || ILLEGAL !== 1'b0) begin
        failures++;
        $display("FAIL single_op[%0d] ctl=%b: got vld=%b rdy=%b res=%h z=%b ill=%b, want 1/0/%h/%b/0",
                 i, v_ctl[i], OUT_VALID, IN_READY, RESULT, ZERO, ILLEGAL, v_r[i], v_z[i]);
      end
      retire();
      checks++;
      if (OUT_VALID !== 1'b0 || IN_READY !== 1'b1) begin
        failures++;
        $display("FAIL single_retire[%0d]: got vld=%b rdy=%b, want 0/1", i, OUT_VALID, IN_READY);
      end
    end
  endtask

  task automatic test_illegal();
    logic [3:0] codes [2];
    codes[0] = 4'b1111;
    codes[1] = 4'b0011;
    for (int i = 0; i < 2; i++) begin
      issue(codes[i], 64'd5, 64'd7);
      checks++;
      if (OUT_VALID !== 1'b1 || RESULT !== 64'd0 || ZERO !== 1'b1 || ILLEGAL !== 1'b1) begin
        failures++;
        $display("FAIL illegal[%b]: got vld=%b res=%h z=%b ill=%b, want 1/0/1/1",
                 codes[i], OUT_VALID, RESULT, ZERO, ILLEGAL);
      end
      retire();
    end
  endtask

  task automatic test_mul();
    logic [63:0] ma [2];
    logic [63:0] mb [2];
    logic [63:0] mr [2];
    logic        mz [2];
    int          edges;
    logic        rdy_bad;
    ma[0] = 64'd3;            mb[0] = '1;               mr[0] = 64'hFFFF_FFFF_FFFF_FFFD; mz[0] = 1'b0;
    ma[1] = 64'h1_0000_0000;  mb[1] = 64'h1_0000_0000;  mr[1] = 64'd0;                   mz[1] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      issue(4'b1000, ma[i], mb[i]);
      edges = 0;
      rdy_bad = 1'b0;
      IN_VALID = 1'b1;
      while (OUT_VALID !== 1'b1 && edges < 200) begin
        if (IN_READY !== 1'b0) rdy_bad = 1'b1;
        @(posedge CLK);
        #1;
        edges++;
      end
      IN_VALID = 1'b0;
      checks++;
      if (edges != 65 || rdy_bad) begin
        failures++;
        $display("FAIL mul_latency[%0d]: got %0d edges (in_ready_seen_high=%b), want 65 edges with in_ready low",
                 i, edges, rdy_bad);
      end
      checks++;
      if (RESULT !== mr[i] || ZERO !== mz[i] || ILLEGAL !== 1'b0) begin
        failures++;
        $display("FAIL mul_result[%0d]: got res=%h z=%b ill=%b, want %h/%b/0",
                 i, RESULT, ZERO, ILLEGAL, mr[i], mz[i]);
      end
      retire();
    end
  endtask

  task automatic test_back_to_back();
    logic bad;
    issue(4'b0010, 64'd20, 64'd22);
    bad = 1'b0;
    @(negedge CLK);
    ALU_CTRL = 4'b0110; A = 64'd9; B = 64'd4; IN_VALID = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge CLK);
      #1;
      if (OUT_VALID !== 1'b1 || IN_READY !== 1'b0 || RESULT !== 64'd42) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL backpressure_hold: got vld=%b rdy=%b res=%h, want 1/0/%h",
               OUT_VALID, IN_READY, RESULT, 64'd42);
    end
    @(negedge CLK);
    OUT_READY = 1'b1;
    @(posedge CLK);
    #1;
    OUT_READY = 1'b0;
    checks++;
    if (OUT_VALID !== 1'b0 || IN_READY !== 1'b1 || RESULT !== 64'd42) begin
      failures++;
      $display("FAIL backpressure_release: got vld=%b rdy=%b res=%h, want 0/1/%h",
               OUT_VALID, IN_READY, RESULT, 64'd42);
    end
    @(posedge CLK);
    #1;
    IN_VALID = 1'b0;
    checks++;
    if (OUT_VALID !== 1'b1 || RESULT !== 64'd5 || ZERO !== 1'b0) begin
      failures++;
      $display("FAIL backpressure_next_op: got vld=%b res=%h z=%b, want 1/%h/0",
               OUT_VALID, RESULT, ZERO, 64'd5);
    end
    retire();
  endtask

  task automatic test_reset_mid_mul();
    logic late;
    issue(4'b0010, 64'd2, 64'd3);
    retire();
    issue(4'b1000, 64'd3, 64'd5);
    for (int c = 0; c < 20; c++) begin
      @(posedge CLK);
      #1;
    end
    #2;
    RST_N = 1'b0;
    #1;
    checks++;
    if (OUT_VALID !== 1'b0 || RESULT !== 64'd0 || ZERO !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_mul_async: got vld=%b res=%h z=%b, want 0/0/0",
               OUT_VALID, RESULT, ZERO);
    end
    @(negedge CLK);
    RST_N = 1'b1;
    #1;
    checks++;
    if (IN_READY !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_mul_ready: got %b, want 1", IN_READY);
    end
    late = 1'b0;
    for (int c = 0; c < 70; c++) begin
      @(posedge CLK);
      #1;
      if (OUT_VALID !== 1'b0) late = 1'b1;
    end
    checks++;
    if (late) begin
      failures++;
      $display("FAIL reset_mid_mul_aborted: got out_valid high after reset, want never");
    end
    issue(4'b0010, 64'd1, 64'd1);
    checks++;
    if (OUT_VALID !== 1'b1 || RESULT !== 64'd2 || ZERO !== 1'b0) begin
      failures++;
      $display("FAIL reset_then_add: got vld=%b res=%h z=%b, want 1/%h/0",
               OUT_VALID, RESULT, ZERO, 64'd2);
    end
    retire();
  endtask

  initial begin
    test_reset();
    test_single_cycle();
    test_illegal();
    test_mul();
    test_back_to_back();
    test_reset_mid_mul();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
